// File: rtl/matmul_stream_sequencer.sv
// Operand/result sequencer for a combinational MxKxN matmul-accumulate datapath.
// Loads A, B and C from a single element stream, captures D = f(A,B,C) once,
// then drains D back out as a row-major element stream with backpressure.
module matmul_stream_sequencer #(
  parameter int unsigned M = 2,
  parameter int unsigned N = 2,
  parameter int unsigned K = 2,
  parameter int unsigned P = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic signed [4*P-1:0]         in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [M-1:0][K-1:0][P-1:0]    A_o,
  output logic [K-1:0][N-1:0][P-1:0]    B_o,
  output logic [M-1:0][N-1:0][4*P-1:0]  C_o,
  input  logic [M-1:0][N-1:0][4*P-1:0]  D_i,
  output logic signed [4*P-1:0]         out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          done_o
);

  localparam int unsigned DW   = 4 * P;
  localparam int unsigned MK   = M * K;
  localparam int unsigned KN   = K * N;
  localparam int unsigned MN   = M * N;
  localparam int unsigned CMAX = (MK > KN) ? ((MK > MN) ? MK : MN) : ((KN > MN) ? KN : MN);
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_C  = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ld_a, ld_b, ld_c, capture;

  logic [MK-1:0][P-1:0]  a_q;
  logic [KN-1:0][P-1:0]  b_q;
  logic [MN-1:0][DW-1:0] c_q;
  logic [MN-1:0][DW-1:0] res_q;

  // Flat row-major storage has the same bit layout as the 2-D operand ports.
  assign A_o = a_q;
  assign B_o = b_q;
  assign C_o = c_q;

  // State and element counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and handshake decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    done_o      = 1'b0;
    ld_a        = 1'b0;
    ld_b        = 1'b0;
    ld_c        = 1'b0;
    capture     = 1'b0;
    case (state_q)
      LOAD_A: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          ld_a = 1'b1;
          if (cnt_q == CW'(MK - 1)) begin
            state_d = LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LOAD_B: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          ld_b = 1'b1;
          if (cnt_q == CW'(KN - 1)) begin
            state_d = LOAD_C;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LOAD_C: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          ld_c = 1'b1;
          if (cnt_q == CW'(MN - 1)) begin
            state_d = COMPUTE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      COMPUTE: begin
        capture = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (cnt_q == CW'(MN - 1)) begin
            done_o  = 1'b1;
            state_d = LOAD_A;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
    endcase
  end

  // Operand registers written at the counter position; held across frames.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      for (int unsigned i = 0; i < MK; i++)
        if (ld_a && (cnt_q == CW'(i))) a_q[i] <= in_data_i[P-1:0];
      for (int unsigned i = 0; i < KN; i++)
        if (ld_b && (cnt_q == CW'(i))) b_q[i] <= in_data_i[P-1:0];
      for (int unsigned i = 0; i < MN; i++)
        if (ld_c && (cnt_q == CW'(i))) c_q[i] <= in_data_i;
    end
  end

  // Result snapshot taken at the end of the single COMPUTE cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q <= '0;
    end else if (capture) begin
      res_q <= D_i;
    end
  end

  // Output element mux, driven in every state from the counter position.
  always_comb begin
    out_data_o = '0;
    for (int unsigned i = 0; i < MN; i++)
      if (cnt_q == CW'(i)) out_data_o = res_q[i];
  end

endmodule
